// File: rtl/iq_boxcar_decimator.sv
// Integrate-and-dump I/Q decimator: averages 2**LOG2_DECIM samples into one valid/ready pair.
// Optional per-channel DC remover in front of the integrators, enabled by defining IQ_DC_BLOCK_EN.
module iq_boxcar_decimator #(
  parameter int IN_W       = 12,
  parameter int LOG2_DECIM = 3,
  parameter int OUT_W      = 16,
  parameter int DC_SHIFT   = 10
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_i,
  input  logic [IN_W-1:0]  in_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_i,
  output logic [OUT_W-1:0] out_q,
  output logic             overrun
);

  localparam int ACC_W = IN_W + LOG2_DECIM;
  localparam logic [LOG2_DECIM-1:0] CNT_LAST = '1;

  if (LOG2_DECIM < 1 || LOG2_DECIM > 8 || OUT_W < IN_W || DC_SHIFT < 1) begin : g_bad_param
    $error("iq_boxcar_decimator: illegal parameter combination");
  end

  logic signed [IN_W-1:0]  d[2];
  logic        [OUT_W-1:0] dat[2];

  logic [LOG2_DECIM-1:0] cnt_q, cnt_d;
  logic                  out_valid_q, out_valid_d;
  logic                  overrun_q, overrun_d;
  logic                  dump;

`ifdef IQ_DC_BLOCK_EN
  localparam int DC_W = IN_W + DC_SHIFT + 1;
  localparam logic signed [DC_W-1:0] SAT_MAX = DC_W'((2 ** (IN_W - 1)) - 1);
  localparam logic signed [DC_W-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [IN_W-1:0] x[2];
  assign x[0] = in_i;
  assign x[1] = in_q;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dc
    logic signed [DC_W-1:0] dc_acc_q, dc_acc_d;
    logic signed [DC_W-1:0] dc_est, diff, d_sat;

    // Sample minus running DC estimate, clamped back into the input range.
    always_comb begin
      dc_est = dc_acc_q >>> DC_SHIFT;
      diff   = DC_W'(x[gi]) - dc_est;
      if (diff > SAT_MAX) begin
        d_sat = SAT_MAX;
      end else if (diff < SAT_MIN) begin
        d_sat = SAT_MIN;
      end else begin
        d_sat = diff;
      end
      dc_acc_d = in_valid ? (dc_acc_q + d_sat) : dc_acc_q;
    end

    assign d[gi] = d_sat[IN_W-1:0];

    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        dc_acc_q <= '0;
      end else begin
        dc_acc_q <= dc_acc_d;
      end
    end
  end
`else
  assign d[0] = in_i;
  assign d[1] = in_q;
`endif

  assign dump = in_valid && (cnt_q == CNT_LAST);

  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    logic signed [ACC_W-1:0] acc_q, acc_d, sum;
    logic signed [IN_W-1:0]  avg;
    logic        [OUT_W-1:0] dat_q, dat_d;

    // Average is the arithmetic shift of the full group sum (floor rounding).
    always_comb begin
      sum   = acc_q + ACC_W'(d[gi]);
      avg   = IN_W'(sum >>> LOG2_DECIM);
      acc_d = acc_q;
      dat_d = dat_q;
      if (dump) begin
        acc_d = '0;
        dat_d = OUT_W'(avg);
      end else if (in_valid) begin
        acc_d = sum;
      end
    end

    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        acc_q <= '0;
        dat_q <= '0;
      end else begin
        acc_q <= acc_d;
        dat_q <= dat_d;
      end
    end

    assign dat[gi] = dat_q;
  end

  // A dump always (re)loads the single output register; overrun flags a lost unaccepted pair.
  always_comb begin
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
    if (in_valid) begin
      cnt_d = dump ? '0 : cnt_q + 1'b1;
    end
    if (dump) begin
      out_valid_d = 1'b1;
      if (out_valid_q && !out_ready) begin
        overrun_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
  assign out_i     = dat[0];
  assign out_q     = dat[1];

endmodule

// File: tb/tb_iq_boxcar_decimator.sv
// Bench for iq_boxcar_decimator (default build): directed literal cases plus a randomized
// run checked every cycle against a group-sum / floor-division reference model.
module tb_iq_boxcar_decimator;

  localparam int IN_W  = 12;
  localparam int OUT_W = 16;
  localparam int DECIM = 8;

  logic             sys_clk = 1'b0;
  logic             sys_rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [IN_W-1:0]  in_i = '0;
  logic [IN_W-1:0]  in_q = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [OUT_W-1:0] out_i;
  logic [OUT_W-1:0] out_q;
  logic             overrun;

  iq_boxcar_decimator #(.IN_W(IN_W), .LOG2_DECIM(3), .OUT_W(OUT_W), .DC_SHIFT(10)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .in_valid (in_valid),
    .in_i     (in_i),
    .in_q     (in_q),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_i    (out_i),
    .out_q    (out_q),
    .overrun  (overrun)
  );

  always #5 sys_clk = ~sys_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Floor division of a group sum by the decimation ratio.
  function automatic int floor_avg(input int s);
    if (s >= 0) return s / DECIM;
    return -((-s + DECIM - 1) / DECIM);
  endfunction

  // Reference model: count samples in the group, sum them, divide when the group is full.
  int               m_cnt = 0;
  int               m_sum_i = 0;
  int               m_sum_q = 0;
  logic             m_valid = 1'b0;
  logic             m_ovr = 1'b0;
  logic [OUT_W-1:0] m_oi = '0;
  logic [OUT_W-1:0] m_oq = '0;
  bit               m_dump;

  always @(posedge sys_clk) begin
    if (sys_rst) begin
      m_cnt = 0; m_sum_i = 0; m_sum_q = 0;
      m_valid = 1'b0; m_ovr = 1'b0; m_oi = '0; m_oq = '0;
    end else begin
      m_dump = 1'b0;
      if (in_valid) begin
        m_sum_i += int'($signed(in_i));
        m_sum_q += int'($signed(in_q));
        m_cnt++;
        if (m_cnt == DECIM) m_dump = 1'b1;
      end
      if (m_dump) begin
        if (m_valid && !out_ready) m_ovr = 1'b1;
        m_valid = 1'b1;
        m_oi = OUT_W'(floor_avg(m_sum_i));
        m_oq = OUT_W'(floor_avg(m_sum_q));
        m_cnt = 0; m_sum_i = 0; m_sum_q = 0;
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
    end
    #1;
    check("model_out_valid", 32'(out_valid), 32'(m_valid));
    check("model_overrun", 32'(overrun), 32'(m_ovr));
    check("model_out_i", 32'(out_i), 32'(m_oi));
    check("model_out_q", 32'(out_q), 32'(m_oq));
  end

  task automatic strobe(input int i, input int q);
    @(negedge sys_clk);
    in_valid = 1'b1;
    in_i = IN_W'(i);
    in_q = IN_W'(q);
    @(negedge sys_clk);
    in_valid = 1'b0;
  endtask

  task automatic group(input int i, input int q);
    for (int k = 0; k < DECIM; k++) strobe(i, q);
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_i", 32'(out_i), 32'd0);
    check("rst_out_q", 32'(out_q), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    sys_rst = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    out_ready = 1'b1;

    // T1: constant group, one-cycle pulse with ready high
    group(100, -100);
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_i", 32'(out_i), 32'h0064);
    check("t1_q", 32'(out_q), 32'hFF9C);
    @(negedge sys_clk);
    check("t1_pulse_end", 32'(out_valid), 32'd0);

    // T2: extremes and floor rounding
    group(-2048, 2047);
    check("t2_i_min", 32'(out_i), 32'hF800);
    check("t2_q_max", 32'(out_q), 32'h07FF);
    strobe(1, 0);
    for (int k = 1; k < DECIM; k++) strobe(0, 0);
    check("t2_floor_pos", 32'(out_i), 32'h0000);
    strobe(-1, 0);
    for (int k = 1; k < DECIM; k++) strobe(0, 0);
    check("t2_floor_neg", 32'(out_i), 32'hFFFF);

    // T3: backpressure over two groups
    @(negedge sys_clk);
    out_ready = 1'b0;
    group(10, 20);
    for (int k = 0; k < 4; k++) strobe(30, 40);
    check("t3_held_valid", 32'(out_valid), 32'd1);
    check("t3_held_i", 32'(out_i), 32'd10);
    check("t3_held_q", 32'(out_q), 32'd20);
    check("t3_no_ovr_yet", 32'(overrun), 32'd0);
    for (int k = 0; k < 4; k++) strobe(30, 40);
    check("t3_new_i", 32'(out_i), 32'd30);
    check("t3_overrun", 32'(overrun), 32'd1);
    out_ready = 1'b1;
    repeat (3) @(negedge sys_clk);
    check("t3_ovr_sticky", 32'(overrun), 32'd1);
    check("t3_drained", 32'(out_valid), 32'd0);

    // T4: accept and dump in the same cycle
    do_reset();
    out_ready = 1'b0;
    group(5, 6);
    for (int k = 0; k < DECIM - 1; k++) strobe(9, -9);
    @(negedge sys_clk);
    in_valid = 1'b1; in_i = IN_W'(9); in_q = IN_W'(-9); out_ready = 1'b1;
    @(negedge sys_clk);
    in_valid = 1'b0; out_ready = 1'b0;
    check("t4_valid", 32'(out_valid), 32'd1);
    check("t4_i", 32'(out_i), 32'd9);
    check("t4_q", 32'(out_q), 32'hFFF7);
    check("t4_overrun", 32'(overrun), 32'd0);

    // T5: reset mid-group discards the partial sum
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) strobe(1000, -1000);
    do_reset();
    group(8, -8);
    check("t5_i", 32'(out_i), 32'd8);
    check("t5_q", 32'(out_q), 32'hFFF8);

    // Randomized traffic with occasional resets; the model process checks every cycle
    for (int c = 0; c < 4000; c++) begin
      @(negedge sys_clk);
      sys_rst   = ($urandom_range(0, 499) == 0);
      in_valid  = ($urandom_range(0, 99) < 60);
      in_i      = IN_W'($urandom_range(0, 4095));
      in_q      = IN_W'($urandom_range(0, 4095));
      out_ready = ($urandom_range(0, 99) < 50);
    end
    @(negedge sys_clk);
    sys_rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge sys_clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
